fu_wb_scheduler: RTL

Tracks occupancy of every execute-stage functional unit and shares the single writeback/ROB result port among them. The decode stage issues an instruction to a unit together with its latency. The block counts that latency down, raises a completion request when the result is due, and grants one unit per cycle to writeback in round-robin order. It drives the `free_units` vector consumed by the decode stage's scoreboard.

---
 rtl/fu_wb_scheduler_pkg.sv | 29 ++
 rtl/fu_wb_scheduler_rr_arbiter.sv | 45 ++++
 rtl/fu_wb_scheduler.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fu_wb_scheduler_pkg.sv
// Shared constants and unit-id encodings for the execute-stage writeback scheduler.
// Unit ids match the control unit's func_unit values.
package fu_wb_scheduler_pkg;

    localparam int NUM_FUNC_UNITS    = 5;
    localparam int FUNC_UNIT_OP_SIZE = 3;
    localparam int ROB_ID_SIZE       = 6;
    localparam int LAT_SIZE          = 4;

    typedef enum logic [FUNC_UNIT_OP_SIZE-1:0] {
        FU_ALU   = 3'd0,
        FU_CALU  = 3'd1,
        FU_PRED  = 3'd2,
        FU_FLOAT = 3'd3,
        FU_MEM   = 3'd4
    } func_unit_e;

    // Countdown start value: a zero latency behaves like a latency of one.
    function automatic logic [LAT_SIZE-1:0] lat_to_cnt(input logic [LAT_SIZE-1:0] lat);
        logic [LAT_SIZE-1:0] res;
        if (lat == {LAT_SIZE{1'b0}}) begin
            res = {LAT_SIZE{1'b0}};
        end else begin
            res = lat - {{(LAT_SIZE-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

endpackage

// File: rtl/fu_wb_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping at N.
// The pointer register is owned by the instantiating block.
module rr_arbiter #(
    parameter int N = 5,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt_oh,
    output logic [W-1:0] gnt_id,
    output logic         any
);

    int start_s;
    int idx_s;

    // Scan from the pointer, wrapping once; an out-of-range pointer restarts at 0.
    always_comb begin
        gnt_oh  = {N{1'b0}};
        gnt_id  = {W{1'b0}};
        any     = 1'b0;
        idx_s   = 0;
        if (int'(ptr) < N) begin
            start_s = int'(ptr);
        end else begin
            start_s = 0;
        end
        for (int k = 0; k < N; k++) begin
            idx_s = start_s + k;
            if (idx_s >= N) begin
                idx_s = idx_s - N;
            end else begin
                idx_s = idx_s;
            end
            if (!any && req[idx_s]) begin
                any            = 1'b1;
                gnt_oh[idx_s]  = 1'b1;
                gnt_id         = W'(idx_s);
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/fu_wb_scheduler.sv
// Functional-unit occupancy tracker and round-robin writeback-port scheduler.
module fu_wb_scheduler
    import fu_wb_scheduler_pkg::*;
#(
    parameter int NUM_FU      = fu_wb_scheduler_pkg::NUM_FUNC_UNITS,
    parameter int FU_ID_SIZE  = fu_wb_scheduler_pkg::FUNC_UNIT_OP_SIZE,
    parameter int LAT_SIZE    = fu_wb_scheduler_pkg::LAT_SIZE,
    parameter int ROB_ID_SIZE = fu_wb_scheduler_pkg::ROB_ID_SIZE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   issue,
    input  logic [FU_ID_SIZE-1:0]  issue_fu,
    input  logic [LAT_SIZE-1:0]    issue_latency,
    input  logic [ROB_ID_SIZE-1:0] issue_rob_id,
    input  logic                   flush,
    input  logic                   wb_ready,
    output logic [NUM_FU-1:0]      free_units,
    output logic                   wb_valid,
    output logic [FU_ID_SIZE-1:0]  wb_fu,
    output logic [ROB_ID_SIZE-1:0] wb_rob_id,
    output logic                   issue_err
);

    logic [NUM_FU-1:0]                  busy_q, busy_d;
    logic [NUM_FU-1:0][LAT_SIZE-1:0]    cnt_q, cnt_d;
    logic [NUM_FU-1:0][ROB_ID_SIZE-1:0] tag_q, tag_d;
    logic [FU_ID_SIZE-1:0]              ptr_q, ptr_d;
    logic                               issue_err_q, issue_err_d;

    logic [NUM_FU-1:0]      req_s;
    logic [NUM_FU-1:0]      gnt_oh_s;
    logic [FU_ID_SIZE-1:0]  gnt_id_s;
    logic                   any_s;
    logic [ROB_ID_SIZE-1:0] gnt_tag_s;
    logic                   xfer_s;
    logic                   in_range_s;
    logic                   tgt_busy_s;
    logic                   issue_ok_s;
    logic [LAT_SIZE-1:0]    issue_cnt_s;

    rr_arbiter #(
        .N (NUM_FU),
        .W (FU_ID_SIZE)
    ) u_arb (
        .req    (req_s),
        .ptr    (ptr_q),
        .gnt_oh (gnt_oh_s),
        .gnt_id (gnt_id_s),
        .any    (any_s)
    );

    // A unit requests writeback once its countdown has expired.
    always_comb begin
        req_s     = {NUM_FU{1'b0}};
        gnt_tag_s = {ROB_ID_SIZE{1'b0}};
        for (int i = 0; i < NUM_FU; i++) begin
            req_s[i]  = busy_q[i] & (cnt_q[i] == {LAT_SIZE{1'b0}});
            gnt_tag_s = gnt_tag_s | (tag_q[i] & {ROB_ID_SIZE{gnt_oh_s[i]}});
        end
    end

    // Offer is a pure function of state and flush so wb_ready never feeds back into it.
    always_comb begin
        wb_valid = any_s & ~flush;
        if (wb_valid) begin
            wb_fu     = gnt_id_s;
            wb_rob_id = gnt_tag_s;
        end else begin
            wb_fu     = {FU_ID_SIZE{1'b0}};
            wb_rob_id = {ROB_ID_SIZE{1'b0}};
        end
        free_units = ~busy_q;
        issue_err  = issue_err_q;
    end

    // Issue qualification; the target's registered busy bit is used, so an issue
    // colliding with that unit's own transfer is rejected.
    always_comb begin
        xfer_s      = wb_valid & wb_ready;
        in_range_s  = ({1'b0, issue_fu} < (FU_ID_SIZE+1)'(NUM_FU));
        tgt_busy_s  = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (issue_fu == FU_ID_SIZE'(i)) begin
                tgt_busy_s = busy_q[i];
            end else begin
                tgt_busy_s = tgt_busy_s;
            end
        end
        issue_ok_s  = issue & ~flush & in_range_s & ~tgt_busy_s;
        issue_cnt_s = lat_to_cnt(issue_latency);
    end

    // Next-state: flush beats transfer and issue; countdown runs on every busy unit.
    always_comb begin
        busy_d      = busy_q;
        cnt_d       = cnt_q;
        tag_d       = tag_q;
        ptr_d       = ptr_q;
        issue_err_d = 1'b0;
        if (flush) begin
            busy_d = {NUM_FU{1'b0}};
            cnt_d  = '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (busy_q[i] && (cnt_q[i] != {LAT_SIZE{1'b0}})) begin
                    cnt_d[i] = cnt_q[i] - {{(LAT_SIZE-1){1'b0}}, 1'b1};
                end else begin
                    cnt_d[i] = cnt_q[i];
                end
                if (xfer_s && gnt_oh_s[i]) begin
                    busy_d[i] = 1'b0;
                end else begin
                    busy_d[i] = busy_d[i];
                end
                if (issue_ok_s && (issue_fu == FU_ID_SIZE'(i))) begin
                    busy_d[i] = 1'b1;
                    cnt_d[i]  = issue_cnt_s;
                    tag_d[i]  = issue_rob_id;
                end else begin
                    tag_d[i] = tag_d[i];
                end
            end
            if (xfer_s) begin
                if (gnt_id_s == FU_ID_SIZE'(NUM_FU-1)) begin
                    ptr_d = {FU_ID_SIZE{1'b0}};
                end else begin
                    ptr_d = gnt_id_s + {{(FU_ID_SIZE-1){1'b0}}, 1'b1};
                end
            end else begin
                ptr_d = ptr_q;
            end
            issue_err_d = issue & ~issue_ok_s;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q      <= {NUM_FU{1'b0}};
            cnt_q       <= '0;
            tag_q       <= '0;
            ptr_q       <= {FU_ID_SIZE{1'b0}};
            issue_err_q <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            tag_q       <= tag_d;
            ptr_q       <= ptr_d;
            issue_err_q <= issue_err_d;
        end
    end

endmodule
